// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding,
// default vectors and the stack-pointer width helper.
package pc_seq_pkg;

    localparam int DEF_AW = 10;

    localparam logic [DEF_AW-1:0] DEF_RESET_VEC = 10'h000;
    localparam logic [DEF_AW-1:0] DEF_IRQ_VEC   = 10'h3F0;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_HOLD = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_BRR  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_RETI = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    // The stack pointer must be able to count 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push writes entry[sp] and increments sp; pop
// decrements sp. The top entry (entry[sp-1]) is presented combinationally
// so a pop can load the PC in the same cycle it is requested.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 4,
    parameter int SPW   = sp_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic [SPW-1:0] sp,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp_reg;

    assign sp    = sp_reg;
    assign full  = (sp_reg == SPW'(DEPTH));
    assign empty = (sp_reg == '0);

    // Storage write: a guarded push lands in the slot addressed by sp.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && sp_reg == SPW'(i))
                mem[i] <= din;
        end
    end

    // Top-of-stack read; zero when empty (the caller never uses it then).
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_reg == SPW'(i + 1))
                top = mem[i];
        end
    end

    // Stack pointer: at most one push or pop per cycle, guarded at the limits.
    always_ff @(posedge clk) begin
        if (rst)
            sp_reg <= '0;
        else if (push && !full)
            sp_reg <= sp_reg + SPW'(1);
        else if (pop && !empty)
            sp_reg <= sp_reg - SPW'(1);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: opcode-driven next-PC select, call/return
// through a hardware stack, and single-level interrupt entry/exit.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int            AW          = 10,
    parameter int            STACK_DEPTH = 4,
    parameter logic [AW-1:0] RESET_VEC   = AW'(DEF_RESET_VEC),
    parameter logic [AW-1:0] IRQ_VEC     = AW'(DEF_IRQ_VEC)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic [AW-1:0]                      badr,
    input  logic                               irq,
    output logic [AW-1:0]                      pc,
    output logic [sp_width(STACK_DEPTH)-1:0]   sp,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               in_isr,
    output logic                               irq_ack,
    output logic                               err_ovf,
    output logic                               err_unf
);

    localparam int SPW = sp_width(STACK_DEPTH);

    logic [AW-1:0] pc_reg, pc_next;
    logic          in_isr_reg, in_isr_next;
    logic          irq_ack_reg, irq_ack_next;
    logic          err_ovf_reg, err_ovf_next;
    logic          err_unf_reg, err_unf_next;
    logic          push, pop;
    logic [AW-1:0] push_data;
    logic [AW-1:0] stk_top;
    logic          irq_take;

    ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .top   (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Interrupt wins over the op, but only if there is room to save the PC;
    // otherwise it simply stays pending.
    assign irq_take = !stall && irq && !in_isr_reg && !stk_full;

    // State register: everything updates together, reset overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_VEC;
            in_isr_reg  <= 1'b0;
            irq_ack_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            in_isr_reg  <= in_isr_next;
            irq_ack_reg <= irq_ack_next;
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
        end
    end

    // Next-state select: stall freezes, then interrupt entry, then the op.
    always_comb begin
        pc_next      = pc_reg;
        in_isr_next  = in_isr_reg;
        irq_ack_next = 1'b0;
        err_ovf_next = err_ovf_reg;
        err_unf_next = err_unf_reg;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = pc_reg;
        if (stall) begin
            // hold everything; irq_ack drops
        end else if (irq_take) begin
            // Save the interrupted PC itself so it re-executes on return.
            push         = 1'b1;
            push_data    = pc_reg;
            pc_next      = IRQ_VEC;
            in_isr_next  = 1'b1;
            irq_ack_next = 1'b1;
        end else begin
            case (op)
                OP_INC:  pc_next = pc_reg + AW'(1);
                OP_JMP:  pc_next = badr;
                OP_BRR:  pc_next = pc_reg + badr;
                OP_CALL: begin
                    if (stk_full) begin
                        err_ovf_next = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = pc_reg + AW'(1);
                        pc_next   = badr;
                    end
                end
                OP_RET, OP_RETI: begin
                    if (stk_empty) begin
                        err_unf_next = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = stk_top;
                        if (op == OP_RETI)
                            in_isr_next = 1'b0;
                    end
                end
                default: pc_next = pc_reg;   // HOLD and reserved
            endcase
        end
    end

    // Outputs straight from the registers.
    always_comb begin
        pc      = pc_reg;
        in_isr  = in_isr_reg;
        irq_ack = irq_ack_reg;
        err_ovf = err_ovf_reg;
        err_unf = err_unf_reg;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd1;
    logic [9:0] badr = '0;
    logic       irq = 1'b0;
    logic [9:0] pc;
    logic [2:0] sp;
    logic       stk_full, stk_empty, in_isr, irq_ack, err_ovf, err_unf;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] INC = 3'd0, HOLD = 3'd1, JMP = 3'd2, BRR = 3'd3,
                           CALL = 3'd4, RET = 3'd5, RETI = 3'd6, RSV = 3'd7;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .op        (op),
        .badr      (badr),
        .irq       (irq),
        .pc        (pc),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .in_isr    (in_isr),
        .irq_ack   (irq_ack),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic step(input logic [2:0] o, input logic [9:0] b, input logic i, input logic s);
        op = o; badr = b; irq = i; stall = s;
        @(posedge clk);
        #1;
        $display("txn rst=%0b op=%0d badr=%h irq=%0b stall=%0b -> pc=%h sp=%0d isr=%0b ack=%0b ovf=%0b unf=%0b",
                 rst, o, b, i, s, pc, sp, in_isr, irq_ack, err_ovf, err_unf);
    endtask

    task automatic expect_st(input string tag, input logic [9:0] e_pc, input logic [2:0] e_sp,
                             input logic e_isr, input logic e_ack);
        check({tag, ".pc"},     32'(pc),      32'(e_pc));
        check({tag, ".sp"},     32'(sp),      32'(e_sp));
        check({tag, ".in_isr"}, 32'(in_isr),  32'(e_isr));
        check({tag, ".ack"},    32'(irq_ack), 32'(e_ack));
    endtask

    task automatic expect_err(input string tag, input logic e_ovf, input logic e_unf);
        check({tag, ".ovf"}, 32'(err_ovf), 32'(e_ovf));
        check({tag, ".unf"}, 32'(err_unf), 32'(e_unf));
    endtask

    task automatic expect_fe(input string tag, input logic e_full, input logic e_empty);
        check({tag, ".full"},  32'(stk_full),  32'(e_full));
        check({tag, ".empty"}, 32'(stk_empty), 32'(e_empty));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(HOLD, 10'h000, 1'b0, 1'b0);
        step(HOLD, 10'h000, 1'b1, 1'b1);
        expect_st("reset", 10'h000, 3'd0, 1'b0, 1'b0);
        expect_err("reset", 1'b0, 1'b0);
        expect_fe("reset", 1'b0, 1'b1);
        rst = 1'b0;

        // Increment and hold
        for (int k = 1; k <= 5; k++) begin
            step(INC, 10'h000, 1'b0, 1'b0);
            check("inc.pc", 32'(pc), k);
        end
        step(HOLD, 10'h000, 1'b0, 1'b0);
        check("hold1.pc", 32'(pc), 32'h5);
        step(HOLD, 10'h000, 1'b0, 1'b0);
        check("hold2.pc", 32'(pc), 32'h5);

        // Wrap at all-ones
        step(JMP, 10'h3FF, 1'b0, 1'b0);
        check("jmp3ff.pc", 32'(pc), 32'h3FF);
        step(INC, 10'h000, 1'b0, 1'b0);
        check("wrap.pc", 32'(pc), 32'h000);

        // Relative branch backwards, absolute jump, reserved op
        step(JMP, 10'h100, 1'b0, 1'b0);
        step(BRR, 10'h3FC, 1'b0, 1'b0);
        check("brr.pc", 32'(pc), 32'h0FC);
        step(BRR, 10'h010, 1'b0, 1'b0);
        check("brr_fwd.pc", 32'(pc), 32'h10C);
        step(JMP, 10'h200, 1'b0, 1'b0);
        check("jmp.pc", 32'(pc), 32'h200);
        step(RSV, 10'h155, 1'b0, 1'b0);
        check("rsv.pc", 32'(pc), 32'h200);

        // Nested call / return
        step(JMP, 10'h010, 1'b0, 1'b0);
        step(CALL, 10'h040, 1'b0, 1'b0);
        expect_st("call1", 10'h040, 3'd1, 1'b0, 1'b0);
        step(CALL, 10'h080, 1'b0, 1'b0);
        expect_st("call2", 10'h080, 3'd2, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("ret1", 10'h041, 3'd1, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("ret2", 10'h011, 3'd0, 1'b0, 1'b0);
        expect_fe("ret2", 1'b0, 1'b1);

        // Fill the stack, overflow, irq blocked by full stack
        step(CALL, 10'h100, 1'b0, 1'b0);
        step(CALL, 10'h101, 1'b0, 1'b0);
        step(CALL, 10'h102, 1'b0, 1'b0);
        step(CALL, 10'h103, 1'b0, 1'b0);
        expect_st("fill", 10'h103, 3'd4, 1'b0, 1'b0);
        expect_fe("fill", 1'b1, 1'b0);
        expect_err("fill", 1'b0, 1'b0);
        step(CALL, 10'h200, 1'b0, 1'b0);
        expect_st("ovf", 10'h103, 3'd4, 1'b0, 1'b0);
        expect_err("ovf", 1'b1, 1'b0);
        step(INC, 10'h000, 1'b1, 1'b0);
        expect_st("irq_full", 10'h104, 3'd4, 1'b0, 1'b0);
        expect_err("irq_full", 1'b1, 1'b0);

        // Unwind, then underflow
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("unw1", 10'h103, 3'd3, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("unw2", 10'h102, 3'd2, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("unw3", 10'h101, 3'd1, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("unw4", 10'h012, 3'd0, 1'b0, 1'b0);
        step(RET, 10'h000, 1'b0, 1'b0);
        expect_st("unf", 10'h012, 3'd0, 1'b0, 1'b0);
        expect_err("unf", 1'b1, 1'b1);
        step(INC, 10'h000, 1'b0, 1'b0);
        check("sticky.pc", 32'(pc), 32'h013);
        expect_err("sticky", 1'b1, 1'b1);

        // Reset clears sticky errors
        rst = 1'b1;
        step(HOLD, 10'h000, 1'b0, 1'b0);
        rst = 1'b0;
        expect_st("rst2", 10'h000, 3'd0, 1'b0, 1'b0);
        expect_err("rst2", 1'b0, 1'b0);

        // Interrupt entry discards the JMP, second irq ignored, RETI returns
        step(JMP, 10'h123, 1'b0, 1'b0);
        step(JMP, 10'h055, 1'b1, 1'b0);
        expect_st("irq", 10'h3F0, 3'd1, 1'b1, 1'b1);
        step(INC, 10'h000, 1'b1, 1'b0);
        expect_st("irq2", 10'h3F1, 3'd1, 1'b1, 1'b0);
        step(RETI, 10'h000, 1'b0, 1'b0);
        expect_st("reti", 10'h123, 3'd0, 1'b0, 1'b0);
        expect_err("reti", 1'b0, 1'b0);

        // RETI outside an ISR behaves as RET
        step(CALL, 10'h050, 1'b0, 1'b0);
        step(RETI, 10'h000, 1'b0, 1'b0);
        expect_st("reti_noisr", 10'h124, 3'd0, 1'b0, 1'b0);
        expect_err("reti_noisr", 1'b0, 1'b0);

        // Stall freezes everything, blocks irq and CALL
        for (int k = 0; k < 3; k++) begin
            step(CALL, 10'h2AA, 1'b1, 1'b1);
            expect_st("stall", 10'h124, 3'd0, 1'b0, 1'b0);
        end
        step(INC, 10'h000, 1'b1, 1'b0);
        expect_st("irq3", 10'h3F0, 3'd1, 1'b1, 1'b1);
        step(CALL, 10'h2AA, 1'b0, 1'b1);
        expect_st("stall_isr", 10'h3F0, 3'd1, 1'b1, 1'b0);

        // Reset in the middle of the handler
        rst = 1'b1;
        step(INC, 10'h000, 1'b1, 1'b0);
        rst = 1'b0;
        expect_st("rst_isr", 10'h000, 3'd0, 1'b0, 1'b0);
        expect_fe("rst_isr", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
